// File: rtl/nn_phase_controller.sv
// Training phase sequencer: ROM weight load, pipeline stall slots, Manhattan
// update passes and epoch iteration, ending on convergence or an epoch limit.
// Outputs are registered, decoded from the next state, cycle counter and pass.
module nn_phase_controller #(
   parameter int ROM_INIT_CYCLES = 4,
   parameter int STALL_CYCLES    = 1,
   parameter int NUM_PASSES      = 2,
   parameter int PASS_CYCLES     = 8,
   parameter int EPOCH_W         = 8,
   parameter int PASS_W          = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  train_en,
   input  logic [EPOCH_W-1:0]    max_epochs,
   input  logic                  training_done,
   output logic                  training_mode,
   output logic                  init_rom_rd,
   output logic                  wasted_cycle_stall,
   output logic                  old_weight_rd,
   output logic                  write_training,
   output logic [PASS_W-1:0]     pass_idx,
   output logic [NUM_PASSES-1:0] pass_finished,
   output logic [EPOCH_W-1:0]    epoch_count,
   output logic                  busy,
   output logic                  stop
);

   // One counter covers every timed phase, so size it for the longest one.
   localparam int MAX_LEN = (ROM_INIT_CYCLES > PASS_CYCLES)
                            ? ((ROM_INIT_CYCLES > STALL_CYCLES) ? ROM_INIT_CYCLES : STALL_CYCLES)
                            : ((PASS_CYCLES > STALL_CYCLES) ? PASS_CYCLES : STALL_CYCLES);
   localparam int CNT_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   localparam logic [CNT_W-1:0]   ROM_LAST   = CNT_W'(ROM_INIT_CYCLES - 1);
   localparam logic [CNT_W-1:0]   STALL_LAST = CNT_W'((STALL_CYCLES > 0) ? STALL_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0]   PASS_LAST  = CNT_W'(PASS_CYCLES - 1);
   localparam logic [PASS_W-1:0]  LAST_PASS  = PASS_W'(NUM_PASSES - 1);
   localparam logic               HAS_STALL  = (STALL_CYCLES > 0);
   localparam logic [EPOCH_W-1:0] EPOCH_MAX  = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ROM_INIT,
      S_STALL,
      S_PASS,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [PASS_W-1:0]    pass_q, pass_d;
   logic [EPOCH_W-1:0]   epoch_q, epoch_d;
   logic [EPOCH_W-1:0]   lim_q, lim_d;
   logic                 train_q, train_d;
   logic                 conv_q, conv_d;
   logic                 to_done_q, to_done_d;   // a stall slot leads to DONE, not PASS

   logic                 epoch_last;
   logic                 training_mode_d, init_rom_rd_d, wasted_cycle_stall_d;
   logic                 old_weight_rd_d, write_training_d, busy_d, stop_d;
   logic [NUM_PASSES-1:0] pass_finished_d;

   // Compared one bit wider so a limit of all-ones is still reachable.
   assign epoch_last = (({1'b0, epoch_q} + {{EPOCH_W{1'b0}}, 1'b1}) == {1'b0, lim_q});

   // Next-state logic: phase sequencing, pass/epoch bookkeeping, convergence latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pass_d    = pass_q;
      epoch_d   = epoch_q;
      lim_d     = lim_q;
      train_d   = train_q;
      conv_d    = conv_q;
      to_done_d = to_done_q;

      // Convergence is remembered during the run and only acted on at an epoch boundary.
      if ((state_q != S_IDLE) && (state_q != S_DONE) && training_done) begin
         conv_d = 1'b1;
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d   = S_ROM_INIT;
               cnt_d     = '0;
               pass_d    = '0;
               epoch_d   = '0;
               conv_d    = 1'b0;
               to_done_d = 1'b0;
               train_d   = train_en;
               lim_d     = (max_epochs == '0) ? EPOCH_W'(1) : max_epochs;
            end
         end
         S_ROM_INIT: begin
            if (cnt_q == ROM_LAST) begin
               cnt_d     = '0;
               to_done_d = ~train_q;
               if (HAS_STALL) state_d = S_STALL;
               else           state_d = train_q ? S_PASS : S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STALL: begin
            if (cnt_q == STALL_LAST) begin
               cnt_d   = '0;
               state_d = to_done_q ? S_DONE : S_PASS;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_PASS: begin
            if (cnt_q == PASS_LAST) begin
               cnt_d = '0;
               if (pass_q == LAST_PASS) begin
                  pass_d  = '0;
                  epoch_d = (epoch_q == EPOCH_MAX) ? epoch_q : epoch_q + 1'b1;
                  if (conv_q || training_done || epoch_last) state_d = S_DONE;
                  else state_d = HAS_STALL ? S_STALL : S_PASS;
               end else begin
                  pass_d  = pass_q + 1'b1;
                  state_d = HAS_STALL ? S_STALL : S_PASS;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode from next-state values so the registered outputs line up with the state.
   always_comb begin
      busy_d               = (state_d != S_IDLE) && (state_d != S_DONE);
      stop_d               = (state_d == S_DONE);
      init_rom_rd_d        = (state_d == S_ROM_INIT);
      wasted_cycle_stall_d = (state_d == S_STALL);
      training_mode_d      = train_d && ((state_d == S_STALL) || (state_d == S_PASS));
      old_weight_rd_d      = (state_d == S_PASS) && (cnt_d != PASS_LAST);
      write_training_d     = (state_d == S_PASS) && (cnt_d == PASS_LAST);
   end

   // One-hot pulse on the final cycle of whichever pass is running.
   for (genvar gi = 0; gi < NUM_PASSES; gi++) begin : g_pass_finished
      assign pass_finished_d[gi] = write_training_d && (pass_d == PASS_W'(gi));
   end

   assign pass_idx    = pass_q;
   assign epoch_count = epoch_q;

   // State, bookkeeping and output registers; reset aborts any run immediately.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q            <= S_IDLE;
         cnt_q              <= '0;
         pass_q             <= '0;
         epoch_q            <= '0;
         lim_q              <= '0;
         train_q            <= 1'b0;
         conv_q             <= 1'b0;
         to_done_q          <= 1'b0;
         training_mode      <= 1'b0;
         init_rom_rd        <= 1'b0;
         wasted_cycle_stall <= 1'b0;
         old_weight_rd      <= 1'b0;
         write_training     <= 1'b0;
         pass_finished      <= '0;
         busy               <= 1'b0;
         stop               <= 1'b0;
      end else begin
         state_q            <= state_d;
         cnt_q              <= cnt_d;
         pass_q             <= pass_d;
         epoch_q            <= epoch_d;
         lim_q              <= lim_d;
         train_q            <= train_d;
         conv_q             <= conv_d;
         to_done_q          <= to_done_d;
         training_mode      <= training_mode_d;
         init_rom_rd        <= init_rom_rd_d;
         wasted_cycle_stall <= wasted_cycle_stall_d;
         old_weight_rd      <= old_weight_rd_d;
         write_training     <= write_training_d;
         pass_finished      <= pass_finished_d;
         busy               <= busy_d;
         stop               <= stop_d;
      end
   end

endmodule

// File: doc/nn_phase_controller.md
Name: nn_phase_controller

Overview:
Parametrised successor to the training control unit of the NN accelerator.
- Sequences the initial weight-ROM load, stall slots, NUM_PASSES Manhattan-update passes per epoch, and epoch iteration.
- Terminates on the external training_done or on a programmable epoch limit.
- Sits between the top-level start/host logic and the weight memory / update datapath.

Parameters:
ROM_INIT_CYCLES, 4, cycles of init_rom_rd asserted after start (>=1)
STALL_CYCLES, 1, wasted pipeline cycles after ROM init and between passes (>=0)
NUM_PASSES, 2, Manhattan passes per epoch (>=1)
PASS_CYCLES, 8, cycles per pass (>=2)
EPOCH_W, 8, width of the epoch limit and the epoch counter
PASS_W, clog2(NUM_PASSES) with minimum 1, width of pass_idx

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  start request, sampled only in IDLE or DONE
train_en  in  1  1=train run, 0=inference-only (ROM init, then DONE); sampled with start
max_epochs  in  EPOCH_W  epoch limit, sampled with start; 0 treated as 1
training_done  in  1  convergence flag, sampled every cycle while busy
training_mode  out  1  high in STALL/PASS states of a train run
init_rom_rd  out  1  high during ROM_INIT
wasted_cycle_stall  out  1  high during STALL
old_weight_rd  out  1  high on pass cycles 0..PASS_CYCLES-2
write_training  out  1  high on pass cycle PASS_CYCLES-1
pass_idx  out  PASS_W  index of the current pass
pass_finished  out  NUM_PASSES  bit p pulses on the last cycle of pass p
epoch_count  out  EPOCH_W  completed epochs
busy  out  1  high in every state except IDLE and DONE
stop  out  1  high and held in DONE

Behaviour:
- Reset (sync): state=IDLE; all outputs 0; conv flag cleared. Reset mid-run aborts at that edge with no partial pulses.
- Outputs are registered/Moore, decoded from the state and the cycle counter.
- States: IDLE, ROM_INIT, STALL, PASS, DONE.
- IDLE/DONE + start=1:
  - Latch train_en and max_epochs (lim = max_epochs==0 ? 1 : max_epochs).
  - Clear epoch_count and the conv flag.
  - Go to ROM_INIT. stop drops on the same edge.
- ROM_INIT: lasts exactly ROM_INIT_CYCLES cycles; then STALL, or directly the next target if STALL_CYCLES=0.
- Leaving ROM_INIT:
  - train_en=0: next target is DONE, reached via STALL. training_mode stays 0 for the whole run.
  - train_en=1: next target is PASS 0.
- STALL: lasts STALL_CYCLES cycles, then enters the target.
- PASS p: lasts PASS_CYCLES cycles.
  - pass_idx=p throughout.
  - Cycle PASS_CYCLES-1: write_training=1 and pass_finished[p]=1.
  - p<NUM_PASSES-1: go to STALL, then PASS p+1.
- End of an epoch (last cycle of pass NUM_PASSES-1): epoch_count increments at that edge. Next state:
  - DONE if conv flag | training_done | (epoch_count+1 == lim);
  - otherwise STALL, then PASS 0 (pass_idx returns to 0).
- conv flag:
  - Set by training_done=1 in any busy cycle.
  - Sticky until start.
  - Takes effect only at the epoch boundary; a pass in flight always completes.
- epoch_count saturates at 2^EPOCH_W-1. With lim=2^EPOCH_W-1 the run ends at that value.
- DONE:
  - stop=1, training_mode=0, epoch_count holds.
  - Stays in DONE until start. start in DONE restarts with the same sequence as from IDLE.
- start while busy is ignored. training_done in IDLE/DONE is ignored.
- Simultaneous rst and start: rst wins.

Test Plan:
- Defaults, train_en=1, max_epochs=1, start pulse at edge E0. Cycle n = n-th cycle after E0.
  - init_rom_rd high cycles 1-4.
  - wasted_cycle_stall high cycle 5.
  - PASS0 cycles 6-13: old_weight_rd 6-12, write_training and pass_finished[0] at 13.
  - Stall cycle 14.
  - PASS1 cycles 15-22: pass_finished[1] at 22.
  - Cycle 23: stop=1, epoch_count=1, busy=0.
- max_epochs=3, training_done=0 -> exactly 6 pass_finished pulses, alternating bits 0,1; stop=1 with epoch_count=3.
- max_epochs=10, training_done pulsed 1 cycle during epoch 2 pass 0 -> pass 1 of that epoch still completes; stop=1 with epoch_count=2.
- train_en=0 -> init_rom_rd cycles 1-4, stall cycle 5, stop at cycle 6; training_mode, old_weight_rd and write_training never 1.
- rst asserted at cycle 10 (mid PASS0) -> at the next edge all outputs 0, state IDLE; a start afterwards replays the scenario-1 timeline from cycle 1.
- Params STALL_CYCLES=0, NUM_PASSES=3, max_epochs=0 -> no wasted_cycle_stall; pass_idx 0,1,2 back-to-back; stop with epoch_count=1; start in DONE restarts with epoch_count cleared to 0.
